dma_desc_queue: RTL and testbench
=================================

# dma_desc_queue

Descriptor queue sitting directly upstream of the outbound DMA engine: software-side register writes push transfer descriptors (start address, length, timer init, reverse, last), and the queue presents the head descriptor on the DMA engine's config valid/ready port, popping it when the engine asserts ready at transfer end (or immediately for zero-length descriptors). It also counts completions from the engine's strobe_complete pulse and produces a coalesced interrupt, so software can post a batch of transfers and take one interrupt.

## Interface
- DEPTH, 16, descriptor entries; power of 2, ≥2
- LW, $clog2(DEPTH)+1, width of level output (derived, not overridden)

- clk  in  1  clock
- srst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous queue clear
- push_valid  in  1  descriptor write request
- push_ready  out  1  queue can accept descriptor
- push_startAddr / push_length / push_timerInit  in  32 each  descriptor fields
- push_reverse / push_last  in  1 each  descriptor flags
- config_valid  out  1  head descriptor valid
- config_ready  in  1  engine consumed head
- config_payload_startAddr / _length / _timerInit  out  32 each  head fields
- config_payload_reverse / _last  out  1 each  head flags
- strobe_complete  in  1  one-cycle transfer-done pulse from engine
- irq_threshold  in  8  completions per interrupt; 0 treated as 1
- interrupt_clear  in  1  clears irq and pending count
- irq  out  1  coalesced interrupt, level
- level  out  LW  occupied entries, 0..DEPTH
- done_count  out  16  total completions since reset, wraps
- overflow  out  1  sticky: push attempted while full
- overflow_clear  in  1  clears overflow

## Operation
- Storage: DEPTH × 98-bit registers, rd_ptr/wr_ptr of $clog2(DEPTH) bits wrapping modulo DEPTH, level register 0..DEPTH.
- push_ready = (level != DEPTH) && !flush. Push accepted when push_valid && push_ready; entry written at wr_ptr, wr_ptr++.
- config_valid = (level != 0) && !flush. config_payload_* driven from entry at rd_ptr (registered storage, muxed out); stable while config_valid && !config_ready.
- Pop when config_valid && config_ready: rd_ptr++. config_ready while config_valid low is ignored.
- level: +1 on push only, −1 on pop only, unchanged on both.
- Full: push_ready low even if a pop occurs the same cycle (no fall-through). push_valid && level==DEPTH sets overflow; descriptor dropped. overflow_clear clears; simultaneous set and clear → set wins.
- Flush: rd_ptr, wr_ptr, level → 0 next cycle; push in flush cycle dropped, overflow not set; done_count, pending, irq, overflow unaffected.
- Completion: strobe_complete increments done_count (16-bit wrap) and pending (8-bit, saturate 255).
- irq set (next cycle) when, after update, pending ≥ max(irq_threshold,1), or when strobe_complete arrives while level==0 (drain flush of partial batch). irq holds until interrupt_clear.
- interrupt_clear: irq → 0, pending → 0; strobe_complete in same cycle → pending = 1 and irq evaluated against that value (new completion never lost).

## Timing
- Reset values: push_ready 1 (after reset deassert, flush low), config_valid 0, config_payload_* 0, irq 0, level 0, done_count 0, overflow 0; all internal pointers and pending 0.
- Push-to-head latency: 1 cycle (push accepted cycle N, config_valid high cycle N+1 when queue was empty).
- Pop-to-next-head: 0 bubble; next entry presented cycle after pop.
- strobe_complete to irq: 1 cycle. level/done_count update 1 cycle after causing event.
- srst mid-operation discards all entries; no partial state retained.
- All outputs registered or decoded from registers only, except push_ready/config_valid which also gate on flush combinationally.

## Test plan
- Push 3 descriptors (lengths 4,8,0) into empty queue, hold config_ready low → config_valid rises 1 cycle after first push, level=3, payload shows length 4 and is stable; pulse config_ready three times → payloads 4,8,0 in order, level=0, config_valid low.
- Fill DEPTH=16 entries, push 17th with simultaneous pop → push_ready 0, 17th dropped, overflow=1, level=15; overflow_clear → overflow=0; wrap: push/pop 40 more → FIFO order preserved across pointer wrap.
- irq_threshold=3, level kept nonzero, 5 strobe_complete pulses → irq rises 1 cycle after 3rd pulse, done_count=5; interrupt_clear coincident with 6th pulse → irq 0, pending=1.
- irq_threshold=4, 2 completions then queue drained, 3rd completion with level==0 → irq=1; irq_threshold=0 → irq after every completion.
- flush with 5 entries queued and push_valid high → level 0 next cycle, pushed descriptor dropped, overflow 0, done_count unchanged.
- Assert srst asynchronously mid-stream with 4 entries and irq=1 → all outputs at reset values immediately, push_ready 1 after release.

Source files
------------

// File: rtl/dma_desc_queue.sv
// Descriptor FIFO in front of the outbound DMA engine, with completion
// counting and a coalesced, level-sensitive interrupt.
module dma_desc_queue #(
    parameter  int DEPTH = 16,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          flush,
    input  logic          push_valid,
    output logic          push_ready,
    input  logic [31:0]   push_startAddr,
    input  logic [31:0]   push_length,
    input  logic [31:0]   push_timerInit,
    input  logic          push_reverse,
    input  logic          push_last,
    output logic          config_valid,
    input  logic          config_ready,
    output logic [31:0]   config_payload_startAddr,
    output logic [31:0]   config_payload_length,
    output logic [31:0]   config_payload_timerInit,
    output logic          config_payload_reverse,
    output logic          config_payload_last,
    input  logic          strobe_complete,
    input  logic [7:0]    irq_threshold,
    input  logic          interrupt_clear,
    output logic          irq,
    output logic [LW-1:0] level,
    output logic [15:0]   done_count,
    output logic          overflow,
    input  logic          overflow_clear
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_ONE  = LW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [97:0]   mem_r [DEPTH];
    logic [AW-1:0] rd_ptr_r;
    logic [AW-1:0] wr_ptr_r;
    logic [LW-1:0] level_r;
    logic [15:0]   done_count_r;
    logic [7:0]    pending_r;
    logic          irq_r;
    logic          overflow_r;

    logic          full_s;
    logic          empty_s;
    logic          push_fire_s;
    logic          pop_fire_s;
    logic [7:0]    pending_nxt_s;
    logic [7:0]    thr_s;
    logic          irq_set_s;
    logic [97:0]   head_s;

    assign full_s       = (level_r == LVL_FULL);
    assign empty_s      = (level_r == '0);
    // Flush gates the handshakes combinationally so nothing moves in the clear cycle.
    assign push_ready   = !full_s && !flush;
    assign config_valid = !empty_s && !flush;
    assign push_fire_s  = push_valid && push_ready;
    assign pop_fire_s   = config_valid && config_ready;

    assign head_s                   = mem_r[rd_ptr_r];
    assign config_payload_startAddr = head_s[97:66];
    assign config_payload_length    = head_s[65:34];
    assign config_payload_timerInit = head_s[33:2];
    assign config_payload_reverse   = head_s[1];
    assign config_payload_last      = head_s[0];

    assign level      = level_r;
    assign done_count = done_count_r;
    assign irq        = irq_r;
    assign overflow   = overflow_r;

    // Descriptor storage; cleared on reset so the idle payload reads as zero.
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 98'd0;
            end
        end else if (push_fire_s) begin
            mem_r[wr_ptr_r] <= {push_startAddr, push_length, push_timerInit,
                                push_reverse, push_last};
        end
    end

    // Read/write pointers and occupancy.
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            level_r  <= '0;
        end else if (flush) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            level_r  <= '0;
        end else begin
            if (push_fire_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_fire_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_fire_s, pop_fire_s})
                2'b10:   level_r <= level_r + LVL_ONE;
                2'b01:   level_r <= level_r - LVL_ONE;
                default: level_r <= level_r;
            endcase
        end
    end

    // Sticky overflow; a new overflow outranks a same-cycle clear.
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            overflow_r <= 1'b0;
        end else if (push_valid && full_s && !flush) begin
            overflow_r <= 1'b1;
        end else if (overflow_clear) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    // Next pending count and interrupt condition; a completion landing on a clear still counts.
    always_comb begin
        pending_nxt_s = pending_r;
        thr_s         = irq_threshold;
        irq_set_s     = 1'b0;
        if (interrupt_clear) begin
            pending_nxt_s = strobe_complete ? 8'd1 : 8'd0;
        end else if (strobe_complete && (pending_r != 8'hFF)) begin
            pending_nxt_s = pending_r + 8'd1;
        end else begin
            pending_nxt_s = pending_r;
        end
        if (irq_threshold == 8'd0) begin
            thr_s = 8'd1;
        end else begin
            thr_s = irq_threshold;
        end
        irq_set_s = (pending_nxt_s >= thr_s) || (strobe_complete && empty_s);
    end

    // Completion counters and the coalesced interrupt.
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            done_count_r <= 16'd0;
            pending_r    <= 8'd0;
            irq_r        <= 1'b0;
        end else begin
            if (strobe_complete) begin
                done_count_r <= done_count_r + 16'd1;
            end
            pending_r <= pending_nxt_s;
            if (interrupt_clear) begin
                irq_r <= irq_set_s;
            end else begin
                irq_r <= irq_r || irq_set_s;
            end
        end
    end

endmodule

// File: tb/tb_dma_desc_queue.sv
// Scoreboard bench for dma_desc_queue: accepted pushes are queued as expected
// heads and compared when the engine side consumes them.
module tb_dma_desc_queue;

    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          srst;
    logic          flush = 1'b0;
    logic          push_valid = 1'b0;
    logic          push_ready;
    logic [31:0]   push_startAddr = 32'd0;
    logic [31:0]   push_length = 32'd0;
    logic [31:0]   push_timerInit = 32'd0;
    logic          push_reverse = 1'b0;
    logic          push_last = 1'b0;
    logic          config_valid;
    logic          config_ready = 1'b0;
    logic [31:0]   config_payload_startAddr;
    logic [31:0]   config_payload_length;
    logic [31:0]   config_payload_timerInit;
    logic          config_payload_reverse;
    logic          config_payload_last;
    logic          strobe_complete = 1'b0;
    logic [7:0]    irq_threshold = 8'd1;
    logic          interrupt_clear = 1'b0;
    logic          irq;
    logic [LW-1:0] level;
    logic [15:0]   done_count;
    logic          overflow;
    logic          overflow_clear = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    logic [97:0] sb[$];

    dma_desc_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .srst(srst), .flush(flush),
        .push_valid(push_valid), .push_ready(push_ready),
        .push_startAddr(push_startAddr), .push_length(push_length),
        .push_timerInit(push_timerInit), .push_reverse(push_reverse),
        .push_last(push_last),
        .config_valid(config_valid), .config_ready(config_ready),
        .config_payload_startAddr(config_payload_startAddr),
        .config_payload_length(config_payload_length),
        .config_payload_timerInit(config_payload_timerInit),
        .config_payload_reverse(config_payload_reverse),
        .config_payload_last(config_payload_last),
        .strobe_complete(strobe_complete), .irq_threshold(irq_threshold),
        .interrupt_clear(interrupt_clear), .irq(irq), .level(level),
        .done_count(done_count), .overflow(overflow),
        .overflow_clear(overflow_clear)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [97:0] head_now();
        return {config_payload_startAddr, config_payload_length, config_payload_timerInit,
                config_payload_reverse, config_payload_last};
    endfunction

    function automatic logic [97:0] mk_desc(input logic [31:0] a, input logic [31:0] l,
                                            input logic [31:0] t, input logic r, input logic la);
        return {a, l, t, r, la};
    endfunction

    function automatic logic [97:0] rand_desc();
        logic [31:0] a, l, t;
        logic [1:0]  f;
        a = $urandom;
        l = $urandom;
        t = $urandom;
        f = 2'($urandom_range(3, 0));
        return {a, l, t, f};
    endfunction

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One cycle of engine/software activity, driven and judged at the negedge.
    task automatic step(input logic do_push, input logic [97:0] d, input logic do_pop);
        if (do_push) begin
            push_valid = 1'b1;
            {push_startAddr, push_length, push_timerInit, push_reverse, push_last} = d;
        end
        if (do_pop) begin
            check("pop_valid", {127'd0, config_valid}, 128'd1);
            if (config_valid) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 128'd1, 128'd0);
                end else begin
                    check("payload", {30'd0, head_now()}, {30'd0, sb.pop_front()});
                end
            end
            config_ready = 1'b1;
        end
        #1;
        if (do_push && push_ready) sb.push_back(d);
        cycle();
        push_valid   = 1'b0;
        config_ready = 1'b0;
    endtask

    task automatic strobe(input logic clr);
        strobe_complete = 1'b1;
        interrupt_clear = clr;
        cycle();
        strobe_complete = 1'b0;
        interrupt_clear = 1'b0;
    endtask

    task automatic irq_clear();
        interrupt_clear = 1'b1;
        cycle();
        interrupt_clear = 1'b0;
    endtask

    initial begin
        logic [97:0] d;
        srst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_push_ready", {127'd0, push_ready}, 128'd1);
        check("rst_config_valid", {127'd0, config_valid}, 128'd0);
        check("rst_payload", {30'd0, head_now()}, 128'd0);
        check("rst_irq", {127'd0, irq}, 128'd0);
        check("rst_level", {123'd0, level}, 128'd0);
        check("rst_done", {112'd0, done_count}, 128'd0);
        check("rst_overflow", {127'd0, overflow}, 128'd0);
        srst = 1'b0;
        cycle();

        // Three descriptors, engine stalled, then three consumes.
        step(1'b1, mk_desc(32'h1000, 32'd4, 32'd7, 1'b0, 1'b0), 1'b0);
        check("latency_valid", {127'd0, config_valid}, 128'd1);
        check("latency_level", {123'd0, level}, 128'd1);
        step(1'b1, mk_desc(32'h2000, 32'd8, 32'd9, 1'b1, 1'b0), 1'b0);
        step(1'b1, mk_desc(32'h3000, 32'd0, 32'd1, 1'b0, 1'b1), 1'b0);
        check("level3", {123'd0, level}, 128'd3);
        check("head_len4", {96'd0, config_payload_length}, 128'd4);
        cycle();
        check("head_stable", {96'd0, config_payload_length}, 128'd4);
        for (int i = 0; i < 3; i++) step(1'b0, 98'd0, 1'b1);
        check("drained_level", {123'd0, level}, 128'd0);
        check("drained_valid", {127'd0, config_valid}, 128'd0);

        // Fill, overflow with simultaneous pop, then wrap the pointers.
        for (int i = 0; i < DEPTH; i++) step(1'b1, rand_desc(), 1'b0);
        check("full_level", {123'd0, level}, 128'd16);
        check("full_ready", {127'd0, push_ready}, 128'd0);
        step(1'b1, rand_desc(), 1'b1);
        check("ovf_set", {127'd0, overflow}, 128'd1);
        check("ovf_level", {123'd0, level}, 128'd15);
        check("ovf_sb_size", 128'(sb.size()), 128'd15);
        overflow_clear = 1'b1;
        cycle();
        overflow_clear = 1'b0;
        check("ovf_clear", {127'd0, overflow}, 128'd0);
        for (int i = 0; i < 40; i++) step(1'b1, rand_desc(), 1'b1);
        check("wrap_level", {123'd0, level}, 128'd15);
        for (int i = 0; i < 15; i++) step(1'b0, 98'd0, 1'b1);
        check("wrap_empty", {123'd0, level}, 128'd0);

        // Threshold coalescing with the queue kept busy.
        step(1'b1, rand_desc(), 1'b0);
        step(1'b1, rand_desc(), 1'b0);
        irq_threshold = 8'd3;
        strobe(1'b0);
        strobe(1'b0);
        check("irq_below_thr", {127'd0, irq}, 128'd0);
        strobe(1'b0);
        check("irq_at_thr", {127'd0, irq}, 128'd1);
        strobe(1'b0);
        strobe(1'b0);
        check("done5", {112'd0, done_count}, 128'd5);
        strobe(1'b1);
        check("clr_with_strobe", {127'd0, irq}, 128'd0);
        check("done6", {112'd0, done_count}, 128'd6);
        strobe(1'b0);
        check("pending2_no_irq", {127'd0, irq}, 128'd0);
        strobe(1'b0);
        check("pending3_irq", {127'd0, irq}, 128'd1);
        irq_clear();
        check("irq_cleared", {127'd0, irq}, 128'd0);

        // Partial batch finishing on an empty queue.
        irq_threshold = 8'd4;
        strobe(1'b0);
        strobe(1'b0);
        check("partial_no_irq", {127'd0, irq}, 128'd0);
        step(1'b0, 98'd0, 1'b1);
        step(1'b0, 98'd0, 1'b1);
        check("partial_empty", {123'd0, level}, 128'd0);
        strobe(1'b0);
        check("drain_irq", {127'd0, irq}, 128'd1);
        check("done11", {112'd0, done_count}, 128'd11);
        irq_clear();

        // Threshold zero behaves as one.
        irq_threshold = 8'd0;
        step(1'b1, rand_desc(), 1'b0);
        strobe(1'b0);
        check("thr0_irq_a", {127'd0, irq}, 128'd1);
        irq_clear();
        check("thr0_clr", {127'd0, irq}, 128'd0);
        strobe(1'b0);
        check("thr0_irq_b", {127'd0, irq}, 128'd1);
        irq_clear();
        step(1'b0, 98'd0, 1'b1);

        // Flush with a push in the same cycle.
        for (int i = 0; i < 5; i++) step(1'b1, rand_desc(), 1'b0);
        check("pre_flush_level", {123'd0, level}, 128'd5);
        flush = 1'b1;
        push_valid = 1'b1;
        #1;
        check("flush_push_ready", {127'd0, push_ready}, 128'd0);
        check("flush_cfg_valid", {127'd0, config_valid}, 128'd0);
        cycle();
        flush = 1'b0;
        push_valid = 1'b0;
        sb.delete();
        check("flush_level", {123'd0, level}, 128'd0);
        check("flush_ovf", {127'd0, overflow}, 128'd0);
        check("flush_done", {112'd0, done_count}, 128'd13);
        check("flush_valid", {127'd0, config_valid}, 128'd0);
        d = rand_desc();
        step(1'b1, d, 1'b0);
        step(1'b0, 98'd0, 1'b1);
        check("post_flush_level", {123'd0, level}, 128'd0);

        // Asynchronous reset in the middle of traffic.
        irq_threshold = 8'd1;
        for (int i = 0; i < 4; i++) step(1'b1, rand_desc(), 1'b0);
        strobe(1'b0);
        check("pre_rst_irq", {127'd0, irq}, 128'd1);
        check("pre_rst_level", {123'd0, level}, 128'd4);
        #2;
        srst = 1'b1;
        #1;
        check("arst_level", {123'd0, level}, 128'd0);
        check("arst_irq", {127'd0, irq}, 128'd0);
        check("arst_valid", {127'd0, config_valid}, 128'd0);
        check("arst_payload", {30'd0, head_now()}, 128'd0);
        check("arst_done", {112'd0, done_count}, 128'd0);
        check("arst_overflow", {127'd0, overflow}, 128'd0);
        @(negedge clk);
        srst = 1'b0;
        sb.delete();
        cycle();
        check("arst_push_ready", {127'd0, push_ready}, 128'd1);
        step(1'b1, rand_desc(), 1'b0);
        step(1'b0, 98'd0, 1'b1);
        check("arst_final_level", {123'd0, level}, 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
